// File: rtl/memory_stage_pkg.sv
// Shared definitions for the memory pipeline stage: op encodings, FSM states
// and default widths.
package memory_stage_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 11;

    localparam logic [2:0] MEM_NONE  = 3'd0;
    localparam logic [2:0] MEM_LOAD  = 3'd1;
    localparam logic [2:0] MEM_STORE = 3'd2;
    localparam logic [2:0] MEM_PUSH  = 3'd3;
    localparam logic [2:0] MEM_POP   = 3'd4;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } stateT;

    // Encodings 5-7 fall through as NONE.
    function automatic logic isMemOp(input logic [2:0] op);
        return (op == MEM_LOAD) || (op == MEM_STORE) || (op == MEM_PUSH) || (op == MEM_POP);
    endfunction

    function automatic logic isReadOp(input logic [2:0] op);
        return (op == MEM_LOAD) || (op == MEM_POP);
    endfunction

    function automatic logic isWriteOp(input logic [2:0] op);
        return (op == MEM_STORE) || (op == MEM_PUSH);
    endfunction

endpackage

// File: rtl/memory_stage_stack_pointer_unit.sv
// Stack pointer register; moves only on committed push/pop and exposes the
// bound flags used to refuse over/underflowing stack ops.
module stack_pointer_unit #(
    parameter int                ADDR_W   = 11,
    parameter logic [ADDR_W-1:0] SP_RESET = {ADDR_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pushCommit,
    input  logic              popCommit,
    output logic [ADDR_W-1:0] sp,
    output logic [ADDR_W-1:0] spPlus1,
    output logic              full,
    output logic              empty
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp <= SP_RESET;
        end else if (pushCommit) begin
            sp <= sp - ADDR_W'(1);
        end else if (popCommit) begin
            sp <= sp + ADDR_W'(1);
        end
    end

    assign spPlus1 = sp + ADDR_W'(1);
    assign full    = (sp == '0);
    assign empty   = (sp == SP_RESET);

endmodule

// File: rtl/memory_stage.sv
// MEM pipeline stage: runs loads/stores/pushes/pops over a req/ack port,
// stalls upstream while an access is outstanding and registers MEM/WB.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                DATA_W   = DEF_DATA_W,
    parameter logic [ADDR_W-1:0] SP_RESET = {ADDR_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic [2:0]        mem_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] store_data,
    input  logic [2:0]        rdst_in,
    input  logic              wb_en_in,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] fwd_data,
    output logic              wb_valid,
    output logic              wb_en,
    output logic [2:0]        wb_rdst,
    output logic [DATA_W-1:0] wb_data,
    output logic [ADDR_W-1:0] sp,
    output logic              stack_err
);

    stateT             state;
    logic [2:0]        accOp;
    logic              accWe;
    logic              accWbEn;
    logic [ADDR_W-1:0] accAddr;
    logic [DATA_W-1:0] accWdata;
    logic [DATA_W-1:0] accAlu;
    logic [2:0]        accRdst;

    logic [ADDR_W-1:0] spPlus1;
    logic              spFull;
    logic              spEmpty;
    logic              opIsMem;
    logic              stackFault;
    logic              startAccess;
    logic              ackCommit;
    logic [ADDR_W-1:0] idleAddr;

    assign opIsMem     = valid_in && isMemOp(mem_op);
    assign stackFault  = (state == IDLE) && valid_in &&
                         (((mem_op == MEM_PUSH) && spFull) || ((mem_op == MEM_POP) && spEmpty));
    assign startAccess = (state == IDLE) && opIsMem && !stackFault;
    assign ackCommit   = (state == ACCESS) && mem_ack;

    always_comb begin
        idleAddr = alu_result[ADDR_W-1:0];
        if (mem_op == MEM_PUSH) begin
            idleAddr = sp;
        end else if (mem_op == MEM_POP) begin
            idleAddr = spPlus1;
        end
    end

    // Reset gates stall so upstream is released the moment an access is aborted.
    assign stall     = rst_n && (startAccess || ((state == ACCESS) && !mem_ack));
    assign mem_req   = (state == ACCESS);
    assign mem_we    = accWe;
    assign mem_addr  = accAddr;
    assign mem_wdata = accWdata;
    assign fwd_data  = alu_result;

    stack_pointer_unit #(
        .ADDR_W   (ADDR_W),
        .SP_RESET (SP_RESET)
    ) uSpUnit (
        .clk        (clk),
        .rst_n      (rst_n),
        .pushCommit (ackCommit && (accOp == MEM_PUSH)),
        .popCommit  (ackCommit && (accOp == MEM_POP)),
        .sp         (sp),
        .spPlus1    (spPlus1),
        .full       (spFull),
        .empty      (spEmpty)
    );

    // Access capture: IDLE -> ACCESS boundary
    always_ff @(posedge clk) begin
        if (startAccess) begin
            accAddr  <= idleAddr;
            accWdata <= store_data;
            accAlu   <= alu_result;
            accRdst  <= rdst_in;
        end
    end

    // MEM/WB boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            accOp     <= MEM_NONE;
            accWe     <= 1'b0;
            accWbEn   <= 1'b0;
            wb_valid  <= 1'b0;
            wb_en     <= 1'b0;
            wb_rdst   <= '0;
            wb_data   <= '0;
            stack_err <= 1'b0;
        end else begin
            stack_err <= stackFault;
            case (state)
                IDLE: begin
                    if (startAccess) begin
                        state    <= ACCESS;
                        accOp    <= mem_op;
                        accWe    <= isWriteOp(mem_op);
                        accWbEn  <= wb_en_in;
                        wb_valid <= 1'b0;
                        wb_en    <= 1'b0;
                    end else if (opIsMem) begin
                        wb_valid <= 1'b0;
                        wb_en    <= 1'b0;
                    end else begin
                        wb_valid <= valid_in;
                        wb_en    <= wb_en_in && valid_in;
                        wb_rdst  <= rdst_in;
                        wb_data  <= alu_result;
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        state    <= IDLE;
                        wb_valid <= 1'b1;
                        wb_en    <= accWbEn;
                        wb_rdst  <= accRdst;
                        wb_data  <= isReadOp(accOp) ? mem_rdata : accAlu;
                    end else begin
                        wb_valid <= 1'b0;
                        wb_en    <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: expected write-backs and memory accesses
// are queued at issue and checked as the DUT produces them.
module tb_memory_stage;
    import memory_stage_pkg::*;

    localparam int AW = 11;
    localparam int DW = 16;
    localparam logic [AW-1:0] SPR = {AW{1'b1}};

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid_in;
    logic [2:0]    mem_op;
    logic [DW-1:0] alu_result;
    logic [DW-1:0] store_data;
    logic [2:0]    rdst_in;
    logic          wb_en_in;
    logic          stall;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] fwd_data;
    logic          wb_valid;
    logic          wb_en;
    logic [2:0]    wb_rdst;
    logic [DW-1:0] wb_data;
    logic [AW-1:0] sp;
    logic          stack_err;

    memory_stage #(.ADDR_W(AW), .DATA_W(DW), .SP_RESET(SPR)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .mem_op(mem_op),
        .alu_result(alu_result), .store_data(store_data), .rdst_in(rdst_in),
        .wb_en_in(wb_en_in), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .fwd_data(fwd_data), .wb_valid(wb_valid),
        .wb_en(wb_en), .wb_rdst(wb_rdst), .wb_data(wb_data), .sp(sp),
        .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          en;
        logic [2:0]    rdst;
        logic [DW-1:0] data;
    } wbExpT;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } accExpT;

    wbExpT         wbQ[$];
    accExpT        accQ[$];
    logic [DW-1:0] tbMem [0:(1<<AW)-1];
    logic [AW-1:0] spModel;
    int            nVec = 0;
    int            nMis = 0;
    int            ackDelay = 1;
    int            reqCycles = 0;

    task automatic chkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nMis++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Memory responder: acks after ackDelay request cycles, checks request against queue.
    initial begin
        int waitCnt;
        accExpT a;
        waitCnt   = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (!mem_req) begin
                waitCnt = 0;
            end else begin
                waitCnt++;
                reqCycles = waitCnt;
                chkVal("acc_pending", 32'(accQ.size() != 0), 32'd1);
                if (accQ.size() != 0) begin
                    a = accQ[0];
                    chkVal("req_we", 32'(mem_we), 32'(a.we));
                    chkVal("req_addr", 32'(mem_addr), 32'(a.addr));
                    if (a.we) chkVal("req_wdata", 32'(mem_wdata), 32'(a.wdata));
                end
                if (waitCnt == ackDelay) begin
                    mem_ack = 1'b1;
                    waitCnt = 0;
                    if (accQ.size() != 0) void'(accQ.pop_front());
                    if (mem_we) tbMem[mem_addr] = mem_wdata;
                    else mem_rdata = tbMem[mem_addr];
                end
            end
        end
    end

    // Write-back monitor
    initial begin
        wbExpT e;
        forever begin
            @(negedge clk);
            if (rst_n && wb_valid) begin
                if (wbQ.size() == 0) begin
                    chkVal("wb_unexpected", 32'd1, 32'd0);
                end else begin
                    e = wbQ.pop_front();
                    chkVal("wb_en", 32'(wb_en), 32'(e.en));
                    chkVal("wb_rdst", 32'(wb_rdst), 32'(e.rdst));
                    chkVal("wb_data", 32'(wb_data), 32'(e.data));
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic [2:0] op, input logic [DW-1:0] alu, input logic [DW-1:0] sd,
                         input logic [2:0] rd, input logic we, input logic expStall);
        int cycles;
        valid_in   = 1'b1;
        mem_op     = op;
        alu_result = alu;
        store_data = sd;
        rdst_in    = rd;
        wb_en_in   = we;
        @(negedge clk);
        chkVal("stall_first", 32'(stall), 32'(expStall));
        chkVal("fwd_data", 32'(fwd_data), 32'(alu));
        cycles = 0;
        while (stall && cycles < 200) begin
            @(negedge clk);
            cycles++;
        end
        if (stall) chkVal("stall_timeout", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        mem_op   = MEM_NONE;
    endtask

    task automatic faultCheck(input string tag);
        chkVal({tag, "_err"}, 32'(stack_err), 32'd1);
        chkVal({tag, "_req"}, 32'(mem_req), 32'd0);
        chkVal({tag, "_wbv"}, 32'(wb_valid), 32'd0);
        chkVal({tag, "_sp"}, 32'(sp), 32'(spModel));
        @(posedge clk);
        #1;
        chkVal({tag, "_pulse"}, 32'(stack_err), 32'd0);
    endtask

    task automatic doAlu(input logic [2:0] op, input logic [DW-1:0] alu, input logic [2:0] rd, input logic we);
        wbQ.push_back('{we, rd, alu});
        issue(op, alu, 16'h0, rd, we, 1'b0);
    endtask

    task automatic doLoad(input logic [DW-1:0] alu, input logic [2:0] rd);
        accQ.push_back('{1'b0, alu[AW-1:0], 16'h0});
        wbQ.push_back('{1'b1, rd, tbMem[alu[AW-1:0]]});
        issue(MEM_LOAD, alu, 16'h0, rd, 1'b1, 1'b1);
    endtask

    task automatic doStore(input logic [DW-1:0] alu, input logic [DW-1:0] sd);
        accQ.push_back('{1'b1, alu[AW-1:0], sd});
        wbQ.push_back('{1'b0, 3'd0, alu});
        issue(MEM_STORE, alu, sd, 3'd0, 1'b0, 1'b1);
    endtask

    task automatic doPush(input logic [DW-1:0] sd);
        if (spModel == '0) begin
            issue(MEM_PUSH, 16'h0, sd, 3'd0, 1'b0, 1'b0);
            faultCheck("ovf");
        end else begin
            accQ.push_back('{1'b1, spModel, sd});
            wbQ.push_back('{1'b0, 3'd0, 16'h0});
            issue(MEM_PUSH, 16'h0, sd, 3'd0, 1'b0, 1'b1);
            spModel = spModel - 1'b1;
            chkVal("push_sp", 32'(sp), 32'(spModel));
        end
    endtask

    task automatic doPop(input logic [2:0] rd);
        logic [AW-1:0] a;
        if (spModel == SPR) begin
            issue(MEM_POP, 16'h0, 16'h0, rd, 1'b1, 1'b0);
            faultCheck("udf");
        end else begin
            a = spModel + 1'b1;
            accQ.push_back('{1'b0, a, 16'h0});
            wbQ.push_back('{1'b1, rd, tbMem[a]});
            issue(MEM_POP, 16'h0, 16'h0, rd, 1'b1, 1'b1);
            spModel = a;
            chkVal("pop_sp", 32'(sp), 32'(spModel));
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) tbMem[i] = 16'(i) ^ 16'h5A5A;
        tbMem[16'h0010] = 16'hBEEF;
        rst_n = 1'b0; valid_in = 1'b0; mem_op = MEM_NONE; alu_result = '0;
        store_data = '0; rdst_in = '0; wb_en_in = 1'b0;
        spModel = SPR;
        repeat (3) @(negedge clk);
        chkVal("rst_wbv", 32'(wb_valid), 32'd0);
        chkVal("rst_wben", 32'(wb_en), 32'd0);
        chkVal("rst_rdst", 32'(wb_rdst), 32'd0);
        chkVal("rst_data", 32'(wb_data), 32'd0);
        chkVal("rst_err", 32'(stack_err), 32'd0);
        chkVal("rst_req", 32'(mem_req), 32'd0);
        chkVal("rst_stall", 32'(stall), 32'd0);
        chkVal("rst_sp", 32'(sp), 32'(SPR));
        rst_n = 1'b1;
        @(posedge clk); #1;

        doAlu(MEM_NONE, 16'h1234, 3'd3, 1'b1);
        doAlu(3'd6, 16'hA5C3, 3'd5, 1'b0);
        doAlu(MEM_NONE, 16'hFFFF, 3'd7, 1'b1);

        ackDelay = 3;
        doLoad(16'h0010, 3'd2);
        chkVal("ld_req_cycles", 32'(reqCycles), 32'd3);
        ackDelay = 1;
        doStore(16'h0020, 16'h1357);
        doLoad(16'hF820, 3'd4);

        doPush(16'h00AA);
        doPop(3'd1);
        doPop(3'd1);
        doPush(16'h0055);

        // Abort an access with reset
        ackDelay = 1000;
        accQ.push_back('{1'b0, 11'h030, 16'h0});
        valid_in = 1'b1; mem_op = MEM_LOAD; alu_result = 16'h0030; rdst_in = 3'd6; wb_en_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chkVal("abort_req_pre", 32'(mem_req), 32'd1);
        chkVal("abort_stall_pre", 32'(stall), 32'd1);
        rst_n = 1'b0;
        #1;
        chkVal("abort_req", 32'(mem_req), 32'd0);
        chkVal("abort_stall", 32'(stall), 32'd0);
        chkVal("abort_sp", 32'(sp), 32'(SPR));
        accQ.delete();
        valid_in = 1'b0; mem_op = MEM_NONE;
        spModel = SPR;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chkVal("abort_wbv", 32'(wb_valid), 32'd0);
        chkVal("abort_req_post", 32'(mem_req), 32'd0);
        chkVal("abort_sp_post", 32'(sp), 32'(SPR));
        ackDelay = 1;
        @(posedge clk); #1;

        for (int i = 0; i < (1 << AW) - 1; i++) doPush(16'(i) ^ 16'h0F0F);
        chkVal("full_sp", 32'(sp), 32'd0);
        doPush(16'hDEAD);
        chkVal("ovf_sp_hold", 32'(sp), 32'd0);

        repeat (3) @(negedge clk);
        chkVal("sb_wb_left", 32'(wbQ.size()), 32'd0);
        chkVal("sb_acc_left", 32'(accQ.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline stage directly downstream of the execute stage. It consumes the ALU result and first operand latched in the EX/MEM buffer.
- Performs load, store, push and pop through a req/ack data-memory port and owns the stack pointer.
- Registers the MEM/WB buffer and supplies the forwarding value that feeds the execute stage's "from Mem" operand muxes.
- Stalls upstream while a memory access is outstanding.

Parameters:
- ADDR_W, 11, data-memory word-address width; stack pointer width.
- DATA_W, 16, datapath width.
- SP_RESET, 2**ADDR_W-1, stack pointer value after reset (top of memory).

Ports:
- clk  in  1  stage clock.
- rst_n  in  1  asynchronous active-low reset.
- valid_in  in  1  EX/MEM entry holds a live instruction.
- mem_op  in  3  0 NONE, 1 LOAD, 2 STORE, 3 PUSH, 4 POP; 5-7 treated as NONE.
- alu_result  in  DATA_W  ALU result; the low ADDR_W bits are the LOAD/STORE address.
- store_data  in  DATA_W  ALU first operand; write data for STORE/PUSH.
- rdst_in  in  3  destination register index.
- wb_en_in  in  1  instruction writes the register file.
- stall  out  1  hold EX/MEM and everything upstream this cycle.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  1 write, 0 read; valid with mem_req.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  write data.
- mem_ack  in  1  access complete this cycle; mem_rdata valid when the access is a read.
- mem_rdata  in  DATA_W  read data.
- fwd_data  out  DATA_W  combinational forward value equal to alu_result.
- wb_valid  out  1  MEM/WB entry valid.
- wb_en  out  1  MEM/WB register-write enable.
- wb_rdst  out  3  MEM/WB destination register.
- wb_data  out  DATA_W  MEM/WB write-back data.
- sp  out  ADDR_W  current stack pointer.
- stack_err  out  1  one-cycle pulse on stack overflow or underflow.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, sp=SP_RESET.
  - wb_valid, wb_en, wb_rdst, wb_data, stack_err all 0.
  - mem_req=0, stall=0.
- FSM states are IDLE and ACCESS.
- IDLE, no valid_in or op NONE:
  - next edge loads wb_valid=valid_in, wb_en=wb_en_in&valid_in, wb_rdst=rdst_in, wb_data=alu_result.
  - stall=0; latency is 1 cycle.
- IDLE, valid LOAD/STORE/PUSH/POP:
  - stall=1 combinationally.
  - Latch addr, we and wdata into internal registers:
    - LOAD: alu_result[ADDR_W-1:0], read.
    - STORE: alu_result[ADDR_W-1:0], write.
    - PUSH: address = sp, write.
    - POP: address = sp+1, read.
  - wdata = store_data. Go to ACCESS.
  - wb_valid=0 at that edge (bubble).
- ACCESS:
  - mem_req=1; mem_we/mem_addr/mem_wdata driven from the latched registers and stable until ack.
  - stall = ~mem_ack.
  - On the mem_ack edge, return to IDLE and load the MEM/WB entry: wb_valid=1, wb_en=latched wb_en, wb_rdst=latched rdst.
  - wb_data on ack: mem_rdata for LOAD/POP, latched alu_result for STORE/PUSH.
  - sp update on ack: PUSH sp←sp-1; POP sp←sp+1.
- Upstream holds its inputs while stall=1. stall drops in the ack cycle so EX/MEM advances on the same edge; a back-to-back memory op is accepted in IDLE on the next cycle.
- Stack bounds:
  - PUSH with sp==0: no request issued, sp unchanged.
  - POP with sp==SP_RESET: no request issued, sp unchanged.
  - In either case stack_err pulses one cycle, wb_valid=0, and there is no stall.
- sp arithmetic wraps modulo 2**ADDR_W only via the guarded cases above, so it never actually wraps.
- mem_ack while in IDLE is ignored.
- Reset asserted during ACCESS:
  - abort immediately, mem_req drops asynchronously.
  - sp keeps no partial update (returns to SP_RESET).

Decomposition:
- Shared package holds:
  - mem_op encodings (MEM_NONE..MEM_POP).
  - FSM state enum {IDLE, ACCESS}.
  - DATA_W/ADDR_W defaults.
- One sub-module: stack_pointer_unit.
  - Holds the sp register and its reset value.
  - Takes push/pop commit strobes.
  - Outputs sp, sp_plus1 and the full/empty flags used for stack_err.

Test Plan:
- Reset then ALU op: valid_in=1, mem_op=NONE, alu_result=16'h1234, rdst=3, wb_en=1 → next cycle wb_valid=1, wb_data=16'h1234, wb_rdst=3; stall never high.
- LOAD with ack after 3 cycles:
  - stimulus: alu_result=16'h0010, mem_rdata=16'hBEEF.
  - mem_req=1, mem_we=0, mem_addr=11'h010 for 3 cycles; stall high during IDLE+ACCESS until the ack cycle.
  - then wb_data=16'hBEEF.
- PUSH then POP:
  - PUSH store_data=16'h00AA at sp=0x7FF → write to 0x7FF, sp=0x7FE.
  - POP → read 0x7FF, sp=0x7FF, wb_data=mem_rdata.
- Underflow: POP at reset sp=0x7FF → stack_err one-cycle pulse, no mem_req, wb_valid=0, sp=0x7FF.
- Overflow: preload sp to 0 via 2047 PUSHes, then PUSH → stack_err=1, sp stays 0.
- Reset mid-access: assert rst_n=0 during ACCESS before ack → mem_req=0 and stall=0 immediately, sp=0x7FF, wb_valid=0 after release.
